// File: rtl/multiplier.sv
// Lane-parallel signed weight multiplier for the integer ESN reservoir.
// Each lane multiplies its signed input by a fixed signed weight. The product
// is saturated to the lane output width and registered, so the latency is one clock.
module multiplier #(
  parameter int data_width     = 3,
  parameter int weight_size    = 2,
  parameter int reservoir_size = 4,
  parameter logic [reservoir_size*weight_size-1:0] WEIGHTS = 8'b11_01_11_01
) (
  input  logic                                                iClk,
  input  logic                                                iRst,
  input  logic [reservoir_size*data_width-1:0]                iData,
  output logic [(data_width+weight_size-1)*reservoir_size-1:0] oValue
);

  localparam int FW = data_width + weight_size;
  localparam int OW = FW - 1;

  localparam logic [OW-1:0] SAT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] SAT_MIN = {1'b1, {(OW-1){1'b0}}};

  logic signed [FW-1:0]         full [reservoir_size];
  logic [reservoir_size*OW-1:0] value_d;
  logic [reservoir_size*OW-1:0] value_q;

  // Full-width signed product per lane; FW bits always hold the exact product
  always_comb begin
    for (int unsigned k = 0; k < reservoir_size; k++) begin
      full[k] = FW'($signed(iData[k*data_width +: data_width])) *
                FW'($signed(WEIGHTS[k*weight_size +: weight_size]));
    end
  end

  // Clamp each product to the OW-bit signed range (overflow when top two bits differ)
  always_comb begin
    value_d = '0;
    for (int unsigned k = 0; k < reservoir_size; k++) begin
      if (full[k][FW-1] != full[k][FW-2]) begin
        value_d[k*OW +: OW] = full[k][FW-1] ? SAT_MIN : SAT_MAX;
      end else begin
        value_d[k*OW +: OW] = full[k][OW-1:0];
      end
    end
  end

  // Output register; async reset discards any in-flight products
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign oValue = value_q;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: one instance with the default weights,
// one instance with every weight at -2 to exercise positive saturation.
module tb_multiplier;

  logic        clk;
  logic        rst;
  logic [11:0] data;
  logic [15:0] val_def;
  logic [15:0] val_neg;

  int checks = 0;
  int errors = 0;

  multiplier dut (
    .iClk   (clk),
    .iRst   (rst),
    .iData  (data),
    .oValue (val_def)
  );

  multiplier #(
    .data_width     (3),
    .weight_size    (2),
    .reservoir_size (4),
    .WEIGHTS        (8'b10_10_10_10)
  ) dut_neg (
    .iClk   (clk),
    .iRst   (rst),
    .iData  (data),
    .oValue (val_neg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: integer arithmetic per lane, clamped to -8..7
  function automatic logic [15:0] model(input logic [11:0] d, input bit neg_weights);
    logic [15:0] r;
    int          x, w, p;
    logic [2:0]  lane;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      lane = d[k*3 +: 3];
      x = int'(lane);
      if (x >= 4) x = x - 8;
      if (neg_weights) w = -2;
      else             w = (k % 2 == 0) ? 1 : -1;
      p = x * w;
      if (p > 7)  p = 7;
      if (p < -8) p = -8;
      r[k*4 +: 4] = 4'(p);
    end
    return r;
  endfunction

  task automatic test_reset();
    rst  = 1'b0;
    data = 12'hFFF;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (val_def !== 16'h0000) begin
      errors++; $display("FAIL reset_immediate_def: got %h expected 0000", val_def);
    end
    checks++;
    if (val_neg !== 16'h0000) begin
      errors++; $display("FAIL reset_immediate_neg: got %h expected 0000", val_neg);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (val_def !== 16'h0000 || val_neg !== 16'h0000) begin
        errors++; $display("FAIL reset_hold: got %h/%h expected 0000/0000", val_def, val_neg);
      end
    end
  endtask

  task automatic test_default();
    @(negedge clk);
    data = 12'b011_001_000_010;
    rst  = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (val_def !== 16'hD102) begin
      errors++; $display("FAIL default_weights: got %h expected D102", val_def);
    end
    checks++;
    if (val_neg !== model(12'b011_001_000_010, 1'b1)) begin
      errors++; $display("FAIL default_neg_inst: got %h expected %h", val_neg, model(12'b011_001_000_010, 1'b1));
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    data = 12'b100_011_111_000;
    @(posedge clk); #1;
    checks++;
    if (val_neg !== 16'b0111_1010_0010_0000) begin
      errors++; $display("FAIL saturation: got %h expected 7A20", val_neg);
    end
    checks++;
    if (val_def !== model(12'b100_011_111_000, 1'b0)) begin
      errors++; $display("FAIL saturation_def_inst: got %h expected %h", val_def, model(12'b100_011_111_000, 1'b0));
    end
  endtask

  task automatic test_neg_extremes();
    @(negedge clk);
    data = 12'b100_100_100_100;
    @(posedge clk); #1;
    // lane0 weight +1 -> -4, lane1 weight -1 -> +4, alternating
    checks++;
    if (val_def !== 16'h4C4C) begin
      errors++; $display("FAIL neg_extremes: got %h expected 4C4C", val_def);
    end
    checks++;
    if (val_neg !== 16'h7777) begin
      errors++; $display("FAIL neg_extremes_sat: got %h expected 7777", val_neg);
    end
  endtask

  task automatic test_zero();
    @(negedge clk);
    data = 12'h000;
    @(posedge clk); #1;
    checks++;
    if (val_def !== 16'h0000 || val_neg !== 16'h0000) begin
      errors++; $display("FAIL zero_data: got %h/%h expected 0000/0000", val_def, val_neg);
    end
  endtask

  task automatic test_streaming();
    logic [11:0] cur;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cur  = 12'($urandom);
      data = cur;
      @(posedge clk); #1;
      checks++;
      if (val_def !== model(cur, 1'b0) || val_neg !== model(cur, 1'b1)) begin
        errors++; $display("FAIL stream_%0d: got %h/%h expected %h/%h", i, val_def, val_neg, model(cur, 1'b0), model(cur, 1'b1));
      end
      #1 data = 12'($urandom);
      #1;
      checks++;
      if (val_def !== model(cur, 1'b0) || val_neg !== model(cur, 1'b1)) begin
        errors++; $display("FAIL stream_glitch_%0d: got %h/%h expected %h/%h", i, val_def, val_neg, model(cur, 1'b0), model(cur, 1'b1));
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [11:0] cur;
    @(negedge clk);
    cur  = 12'($urandom) | 12'h924;
    data = cur;
    @(posedge clk); #1;
    checks++;
    if (val_def !== model(cur, 1'b0)) begin
      errors++; $display("FAIL pre_reset: got %h expected %h", val_def, model(cur, 1'b0));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (val_def !== 16'h0000 || val_neg !== 16'h0000) begin
      errors++; $display("FAIL mid_reset_async: got %h/%h expected 0000/0000", val_def, val_neg);
    end
    @(negedge clk);
    cur  = 12'($urandom);
    data = cur;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (val_def !== 16'h0000 || val_neg !== 16'h0000) begin
      errors++; $display("FAIL post_release_hold: got %h/%h expected 0000/0000", val_def, val_neg);
    end
    @(posedge clk); #1;
    checks++;
    if (val_def !== model(cur, 1'b0) || val_neg !== model(cur, 1'b1)) begin
      errors++; $display("FAIL first_after_reset: got %h/%h expected %h/%h", val_def, val_neg, model(cur, 1'b0), model(cur, 1'b1));
    end
  endtask

  task automatic test_random();
    logic [11:0] cur;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cur  = 12'($urandom);
      data = cur;
      @(posedge clk); #1;
      checks++;
      if (val_def !== model(cur, 1'b0) || val_neg !== model(cur, 1'b1)) begin
        errors++; $display("FAIL random_%0d: data %h got %h/%h expected %h/%h", i, cur, val_def, val_neg, model(cur, 1'b0), model(cur, 1'b1));
      end
    end
  endtask

  initial begin
    rst  = 1'b0;
    data = '0;
    test_reset();
    test_default();
    test_saturation();
    test_neg_extremes();
    test_zero();
    test_streaming();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
